// File: rtl/sar_ctrl_pkg.sv
// Shared types and helpers for the SAR conversion sequencer.
package sar_ctrl_pkg;

  localparam int DW_DEFAULT = 9;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    CONV   = 3'd2,
    GAP    = 3'd3,
    DONE   = 3'd4
  } state_t;

  // sar9b presents DATA as [0:8] with index 0 the MSB; reorder to [8:0].
  function automatic logic [8:0] bitrev9(input logic [0:8] d);
    logic [8:0] r;
    r = '0;
    for (int i = 0; i < 9; i++) r[8-i] = d[i];
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N_CH = 4,
  localparam int IW = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [N_CH-1:0] gnt,
  output logic [IW-1:0]   idx
);

  // Scan from the pointer upward and take the first active request.
  always_comb begin
    int   c;
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int k = 0; k < N_CH; k++) begin
      c = (int'(ptr) + k) % N_CH;
      if (!found && req[c]) begin
        found  = 1'b1;
        idx    = IW'(c);
        gnt[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sar_conv_seq.sv
// Conversion sequencer for the sar9b ADC: round-robin channel grant, settle,
// repeated conversions with EN-low gaps, 2^k averaging, valid/ready result.
//
// Result handshake: OUT_VALID rises in DONE with OUT_DATA/OUT_CH stable and
// stays high until the cycle OUT_READY is also high; the transfer happens on
// that clock edge and the FSM returns to IDLE. OUT_VALID never drops without
// a transfer.
module sar_conv_seq
  import sar_ctrl_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int DW         = DW_DEFAULT,
  parameter int AVG_MAX    = 3,
  parameter int SETTLE_CYC = 4,
  parameter int EN_LOW_CYC = 2,
  parameter int TIMEOUT    = 63
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [N_CH-1:0]              REQ,
  input  logic [$clog2(AVG_MAX+1)-1:0] AVG_SEL,
  output logic [$clog2(N_CH)-1:0]      MUX_SEL,
  output logic                         ADC_EN,
  input  logic                         ADC_CKO,
  input  logic [0:DW-1]                ADC_DATA,
  output logic                         OUT_VALID,
  input  logic                         OUT_READY,
  output logic [DW-1:0]                OUT_DATA,
  output logic [$clog2(N_CH)-1:0]      OUT_CH,
  output logic                         BUSY,
  output logic                         ERR_TO,
  output logic [2:0]                   DBG_STATE
);

  localparam int IW   = $clog2(N_CH);
  localparam int AW   = $clog2(AVG_MAX + 1);
  localparam int CW   = AVG_MAX + 1;
  localparam int ACCW = DW + AVG_MAX;
  localparam int TW   = $clog2(SETTLE_CYC + EN_LOW_CYC + TIMEOUT + 1);

  state_t          state, state_nx;
  logic [TW-1:0]   timer;
  logic [2:0]      cko_s;
  logic            cko_edge;
  logic [IW-1:0]   ptr, grant, arb_idx;
  logic [N_CH-1:0] arb_gnt;
  logic            any_req;
  logic [AW-1:0]   avg, avg_clamp;
  logic [ACCW-1:0] acc;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            last;
  logic [DW-1:0]   data_ord;
  logic            ld_grant, acc_add, to_hit, hs;
  logic            en_r, err_r;

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req (REQ),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  generate
    if (DW == 9) begin : g_rev9
      assign data_ord = bitrev9(ADC_DATA);
    end else begin : g_rev
      for (genvar i = 0; i < DW; i++) begin : g_bit
        assign data_ord[DW-1-i] = ADC_DATA[i];
      end
    end
  endgenerate

  assign any_req   = |arb_gnt;
  assign avg_clamp = (int'(AVG_SEL) > AVG_MAX) ? AW'(AVG_MAX) : AVG_SEL;
  assign cko_edge  = cko_s[1] & ~cko_s[2];
  assign cnt_nx    = cnt + 1'b1;
  assign last      = (cnt_nx == (CW'(1) << avg));

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_nx = state;
    ld_grant = 1'b0;
    acc_add  = 1'b0;
    to_hit   = 1'b0;
    hs       = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          ld_grant = 1'b1;
          state_nx = SETTLE;
        end
      end
      SETTLE: begin
        if (timer == TW'(SETTLE_CYC - 1)) state_nx = CONV;
      end
      CONV: begin
        // A CKO edge in the timeout cycle still counts as a good sample.
        if (cko_edge) begin
          acc_add  = 1'b1;
          state_nx = last ? DONE : GAP;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          to_hit   = 1'b1;
          state_nx = IDLE;
        end
      end
      GAP: begin
        if (timer == TW'(EN_LOW_CYC - 1)) state_nx = CONV;
      end
      DONE: begin
        if (OUT_READY) begin
          hs       = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: CKO synchroniser, shared timer, grant latch, accumulator, pointer.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cko_s <= '0;
      timer <= '0;
      grant <= '0;
      avg   <= '0;
      acc   <= '0;
      cnt   <= '0;
      ptr   <= '0;
      en_r  <= 1'b0;
      err_r <= 1'b0;
    end else begin
      cko_s <= {cko_s[1:0], ADC_CKO};
      timer <= (state_nx != state) ? '0 : timer + 1'b1;
      en_r  <= (state_nx == CONV);
      err_r <= to_hit;
      if (ld_grant) begin
        grant <= arb_idx;
        avg   <= avg_clamp;
        acc   <= '0;
        cnt   <= '0;
      end
      if (acc_add) begin
        acc <= acc + ACCW'(data_ord);
        cnt <= cnt_nx;
      end
      if (hs || to_hit) ptr <= (grant == IW'(N_CH - 1)) ? '0 : grant + 1'b1;
    end
  end

  assign MUX_SEL   = grant;
  assign ADC_EN    = en_r;
  assign ERR_TO    = err_r;
  assign BUSY      = (state != IDLE);
  assign OUT_VALID = (state == DONE);
  assign OUT_DATA  = OUT_VALID ? DW'(acc >> avg) : '0;
  assign OUT_CH    = OUT_VALID ? grant : '0;
  assign DBG_STATE = state;

endmodule

// File: tb/tb_sar_conv_seq.sv
// Bench for sar_conv_seq: behavioural sar9b model, directed scenarios and a
// scoreboard that checks every result transfer against an expected queue.
module tb_sar_conv_seq;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] REQ = '0;
  logic [1:0] AVG_SEL = '0;
  logic [1:0] MUX_SEL;
  logic       ADC_EN;
  logic       ADC_CKO = 1'b0;
  logic [0:8] ADC_DATA = '0;
  logic       OUT_VALID;
  logic       OUT_READY = 1'b1;
  logic [8:0] OUT_DATA;
  logic [1:0] OUT_CH;
  logic       BUSY;
  logic       ERR_TO;
  logic [2:0] DBG_STATE;

  logic [10:0] exp_q[$];   // {channel, data}
  logic [8:0]  adc_q[$];   // samples the ADC model returns, in order
  logic [8:0]  adc_v;
  int n_checks   = 0;
  int n_errors   = 0;
  int adc_delay  = 20;
  int en_cnt     = 0;
  int err_pulses = 0;
  bit adc_dead   = 1'b0;

  sar_conv_seq dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ       (REQ),
    .AVG_SEL   (AVG_SEL),
    .MUX_SEL   (MUX_SEL),
    .ADC_EN    (ADC_EN),
    .ADC_CKO   (ADC_CKO),
    .ADC_DATA  (ADC_DATA),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_DATA  (OUT_DATA),
    .OUT_CH    (OUT_CH),
    .BUSY      (BUSY),
    .ERR_TO    (ERR_TO),
    .DBG_STATE (DBG_STATE)
  );

  // Clock.
  always #5 CLK = ~CLK;

  // sar9b model: CKO rises adc_delay cycles after EN, DATA MSB-first at index 0.
  always @(negedge CLK) begin
    if (!ADC_EN) begin
      en_cnt  = 0;
      ADC_CKO = 1'b0;
    end else begin
      en_cnt++;
      if (!adc_dead && en_cnt == adc_delay) begin
        adc_v = (adc_q.size() > 0) ? adc_q.pop_front() : 9'h000;
        for (int i = 0; i < 9; i++) ADC_DATA[i] = adc_v[8-i];
        ADC_CKO = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every transfer must match the head of exp_q.
  always @(negedge CLK) begin
    if (ERR_TO === 1'b1) err_pulses++;
    if (!RST && OUT_VALID && OUT_READY) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_out: got ch=%0d data=0x%0h with nothing expected", OUT_CH, OUT_DATA);
      end else begin
        chk("out_ch_data", {21'd0, OUT_CH, OUT_DATA}, {21'd0, exp_q.pop_front()});
      end
    end
  end

  function automatic logic sig_of(input int sel);
    case (sel)
      0:       return BUSY;
      1:       return ADC_EN;
      2:       return OUT_VALID;
      default: return ERR_TO;
    endcase
  endfunction

  // Waits (sampling #1 after each rising edge) until a signal reaches val.
  task automatic wait_sig(input int sel, input logic val, input int limit,
                          input string name, output int cyc);
    cyc = 0;
    while (sig_of(sel) !== val) begin
      if (cyc >= limit) begin
        n_checks++;
        n_errors++;
        $display("FAIL %s: still not %b after %0d cycles", name, val, cyc);
        return;
      end
      @(posedge CLK); #1;
      cyc++;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  initial begin
    int cyc, pulses, min_gap, low_run;
    logic prev_en;

    // Reset state.
    tick(3);
    chk("reset_outputs", {ADC_EN, OUT_VALID, BUSY, ERR_TO, MUX_SEL, OUT_CH, OUT_DATA, DBG_STATE}, 32'd0);
    RST = 1'b0;
    tick(2);

    // 1: single request on channel 2, no averaging, data 0x101.
    adc_delay = 20;
    AVG_SEL = 2'd0;
    adc_q.push_back(9'h101);
    exp_q.push_back({2'd2, 9'h101});
    REQ = 4'b0100;
    wait_sig(0, 1'b1, 50, "t1_grant", cyc);
    REQ = 4'b0000;
    chk("t1_mux_sel", MUX_SEL, 2);
    wait_sig(1, 1'b1, 50, "t1_en", cyc);
    chk("t1_en_delay", cyc, 4);
    wait_sig(0, 1'b0, 500, "t1_done", cyc);
    tick(2);

    // 2: average four samples on channel 3; EN low >= 2 cycles between pulses.
    adc_delay = 5;
    AVG_SEL = 2'd2;
    adc_q.push_back(9'd100); adc_q.push_back(9'd101);
    adc_q.push_back(9'd102); adc_q.push_back(9'd103);
    exp_q.push_back({2'd3, 9'd101});
    REQ = 4'b1000;
    wait_sig(0, 1'b1, 50, "t2_grant", cyc);
    REQ = 4'b0000;
    pulses = 0; min_gap = 999; low_run = 0; prev_en = 1'b0; cyc = 0;
    while (BUSY && cyc < 1000) begin
      @(posedge CLK); #1;
      cyc++;
      if (ADC_EN && !prev_en) begin
        if (pulses > 0 && low_run < min_gap) min_gap = low_run;
        pulses++;
      end
      low_run = ADC_EN ? 0 : low_run + 1;
      prev_en = ADC_EN;
    end
    chk("t2_en_pulses", pulses, 4);
    chk("t2_min_en_low_ok", (min_gap >= 2), 1);
    tick(2);

    // 3: all channels requesting, grants rotate 0,1,2,3,0.
    adc_delay = 8;
    AVG_SEL = 2'd0;
    for (int i = 0; i < 5; i++) begin
      adc_q.push_back(9'(10 * (i + 1)));
      exp_q.push_back({2'(i % 4), 9'(10 * (i + 1))});
    end
    REQ = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_sig(2, 1'b1, 200, "t3_valid", cyc);
      if (i == 4) REQ = 4'b0000;
      tick(1);
    end
    wait_sig(0, 1'b0, 50, "t3_idle", cyc);
    tick(2);

    // 4: ADC never answers -> timeout 63 cycles after EN, next grant moves on.
    adc_dead = 1'b1;
    adc_delay = 6;
    REQ = 4'b0110;
    wait_sig(0, 1'b1, 50, "t4_grant", cyc);
    chk("t4_mux_sel", MUX_SEL, 1);
    wait_sig(1, 1'b1, 50, "t4_en", cyc);
    wait_sig(3, 1'b1, 200, "t4_err", cyc);
    chk("t4_timeout_cycles", cyc, 63);
    adc_dead = 1'b0;
    adc_q.push_back(9'h0AA);
    exp_q.push_back({2'd2, 9'h0AA});
    tick(1);
    chk("t4_err_one_cycle", ERR_TO, 0);
    chk("t4_next_grant", {BUSY, MUX_SEL}, {1'b1, 2'd2});
    REQ = 4'b0000;
    wait_sig(0, 1'b0, 500, "t4_done", cyc);
    tick(2);

    // 5: back-pressure in DONE with full-scale 8-sample average.
    adc_delay = 4;
    AVG_SEL = 2'd3;
    for (int i = 0; i < 8; i++) adc_q.push_back(9'h1FF);
    exp_q.push_back({2'd3, 9'h1FF});
    OUT_READY = 1'b0;
    REQ = 4'b1111;
    wait_sig(2, 1'b1, 500, "t5_valid", cyc);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("t5_hold", {OUT_VALID, ADC_EN, BUSY, MUX_SEL, OUT_CH, OUT_DATA},
          {1'b1, 1'b0, 1'b1, 2'd3, 2'd3, 9'h1FF});
    end
    REQ = 4'b0000;
    OUT_READY = 1'b1;
    wait_sig(0, 1'b0, 50, "t5_done", cyc);
    tick(2);

    // 6: reset during CONV, then a fresh request completes.
    adc_delay = 40;
    AVG_SEL = 2'd0;
    REQ = 4'b0010;
    wait_sig(0, 1'b1, 50, "t6_grant", cyc);
    wait_sig(1, 1'b1, 50, "t6_en", cyc);
    tick(3);
    RST = 1'b1;
    #1;
    chk("t6_reset_async", {ADC_EN, OUT_VALID, BUSY, ERR_TO, MUX_SEL, OUT_CH, OUT_DATA, DBG_STATE}, 32'd0);
    tick(2);
    adc_delay = 20;
    adc_q.push_back(9'h055);
    exp_q.push_back({2'd1, 9'h055});
    RST = 1'b0;
    wait_sig(0, 1'b1, 50, "t6_regrant", cyc);
    chk("t6_mux_sel", MUX_SEL, 1);
    REQ = 4'b0000;
    wait_sig(0, 1'b0, 500, "t6_done", cyc);
    tick(3);

    chk("all_results_seen", exp_q.size(), 0);
    chk("err_pulse_count", err_pulses, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
